// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory arbiter: store/load type
// codes, the grant encoding, the muxed request record and the access size.
package dmem_pkg;

  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_C    = 2'd1,
    GNT_D    = 2'd2
  } grant_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  store_type;
    logic [2:0]  load_type;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Bytes touched by an access; 0 marks an unused type encoding.
  function automatic logic [2:0] access_size(input logic       we,
                                             input logic [1:0] store_type,
                                             input logic [2:0] load_type);
    logic [2:0] size;
    size = 3'd0;
    if (we) begin
      case (store_type)
        ST_SB:   size = 3'd1;
        ST_SH:   size = 3'd2;
        ST_SW:   size = 3'd4;
        default: size = 3'd0;
      endcase
    end else begin
      case (load_type)
        LD_LB, LD_LBU: size = 3'd1;
        LD_LH, LD_LHU: size = 3'd2;
        LD_LW:         size = 3'd4;
        default:       size = 3'd0;
      endcase
    end
    return size;
  endfunction

endpackage

// File: rtl/dmem_req_check.sv
// Combinational legality screen for one memory request: bad type encoding,
// misalignment for the access size, or a footprint running past MEM_BYTES.
module dmem_req_check
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        we,
  input  logic [1:0]  store_type,
  input  logic [2:0]  load_type,
  input  logic [31:0] addr,
  output logic        err
);

  logic [2:0]  size;
  logic [32:0] end_addr;
  logic        type_err;
  logic        align_err;
  logic        range_err;

  always_comb begin
    size      = access_size(we, store_type, load_type);
    type_err  = (size == 3'd0);
    align_err = ((size == 3'd2) && addr[0]) ||
                ((size == 3'd4) && (addr[1:0] != 2'b00));
    // One bit wider so addresses near 2^32 cannot wrap back into range.
    end_addr  = {1'b0, addr} + {30'd0, size};
    range_err = (end_addr > 33'(MEM_BYTES));
    err       = type_err | align_err | range_err;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the data memory unit: fixed priority to the
// pipeline port C with a starvation override for the DMA port D.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES    = 1024,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        c_valid,
  output logic        c_ready,
  input  logic        c_we,
  input  logic [1:0]  c_store_type,
  input  logic [2:0]  c_load_type,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_rsp_valid,
  output logic        c_rsp_err,
  output logic [31:0] c_rsp_rdata,

  input  logic        d_valid,
  output logic        d_ready,
  input  logic        d_we,
  input  logic [1:0]  d_store_type,
  input  logic [2:0]  d_load_type,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic        d_rsp_err,
  output logic [31:0] d_rsp_rdata,

  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_store_type,
  output logic [2:0]  mem_load_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_memtoreg,
  input  logic [31:0] mem_wb_data
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  grant_e          grant;
  req_t            c_req;
  req_t            d_req;
  req_t            req;
  logic            req_err;
  logic            c_acc;
  logic            d_acc;
  logic            accept;
  logic            legal;
  logic [31:0]     rsp_rdata_next;
  logic [CNT_W-1:0] starve_cnt;

  assign c_req = {c_we, c_store_type, c_load_type, c_addr, c_wdata};
  assign d_req = {d_we, d_store_type, d_load_type, d_addr, d_wdata};

  // Handshake: a request transfers in any cycle where valid & ready are both
  // high; ready is the same-cycle grant and never depends on the response
  // path. A requester left waiting (valid & !ready) keeps its fields stable.
  always_comb begin
    grant = GNT_NONE;
    if (!rst) begin
      if (d_valid && (starve_cnt == STARVE_MAX)) grant = GNT_D;
      else if (c_valid)                          grant = GNT_C;
      else if (d_valid)                          grant = GNT_D;
    end
  end

  assign c_ready = (grant == GNT_C);
  assign d_ready = (grant == GNT_D);
  assign c_acc   = c_valid & c_ready;
  assign d_acc   = d_valid & d_ready;
  assign accept  = c_acc | d_acc;

  assign req = d_ready ? d_req : c_req;

  dmem_req_check #(
    .MEM_BYTES (MEM_BYTES)
  ) u_req_check (
    .we         (req.we),
    .store_type (req.store_type),
    .load_type  (req.load_type),
    .addr       (req.addr),
    .err        (req_err)
  );

  assign legal = accept & ~req_err;

  // Illegal or idle cycles present an all-zero command so memory stays put.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_store_type = 2'b00;
    mem_load_type  = 3'b000;
    mem_addr       = 32'd0;
    mem_wdata      = 32'd0;
    if (legal) begin
      mem_read       = ~req.we;
      mem_write      = req.we;
      mem_store_type = req.store_type;
      mem_load_type  = req.load_type;
      mem_addr       = req.addr;
      mem_wdata      = req.wdata;
    end
  end

  assign mem_memtoreg   = mem_read;
  assign rsp_rdata_next = (legal && !req.we) ? mem_wb_data : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_rsp_valid <= 1'b0;
      c_rsp_err   <= 1'b0;
      c_rsp_rdata <= 32'd0;
      d_rsp_valid <= 1'b0;
      d_rsp_err   <= 1'b0;
      d_rsp_rdata <= 32'd0;
      starve_cnt  <= '0;
    end else begin
      c_rsp_valid <= c_acc;
      d_rsp_valid <= d_acc;
      if (c_acc) begin
        c_rsp_err   <= req_err;
        c_rsp_rdata <= rsp_rdata_next;
      end
      if (d_acc) begin
        d_rsp_err   <= req_err;
        d_rsp_rdata <= rsp_rdata_next;
      end
      if (d_valid && !d_ready) begin
        if (starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-addressed memory
// standing in for the data memory unit.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        c_valid, c_ready, c_we;
  logic [1:0]  c_store_type;
  logic [2:0]  c_load_type;
  logic [31:0] c_addr, c_wdata;
  logic        c_rsp_valid, c_rsp_err;
  logic [31:0] c_rsp_rdata;
  logic        d_valid, d_ready, d_we;
  logic [1:0]  d_store_type;
  logic [2:0]  d_load_type;
  logic [31:0] d_addr, d_wdata;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_rdata;
  logic        mem_read, mem_write, mem_memtoreg;
  logic [1:0]  mem_store_type;
  logic [2:0]  mem_load_type;
  logic [31:0] mem_addr, mem_wdata, mem_wb_data;

  dmem_arbiter #(.MEM_BYTES(1024), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .c_valid(c_valid), .c_ready(c_ready), .c_we(c_we),
    .c_store_type(c_store_type), .c_load_type(c_load_type),
    .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rsp_err(c_rsp_err), .c_rsp_rdata(c_rsp_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_we(d_we),
    .d_store_type(d_store_type), .d_load_type(d_load_type),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_err(d_rsp_err), .d_rsp_rdata(d_rsp_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_store_type(mem_store_type), .mem_load_type(mem_load_type),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_memtoreg(mem_memtoreg), .mem_wb_data(mem_wb_data)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  // ---------------- memory model ----------------
  logic [7:0] mem [0:1023];
  logic [7:0] b0, b1, b2, b3;

  initial for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[9:0]] <= mem_wdata[7:0];
      if (mem_store_type != ST_SB) mem[mem_addr[9:0] + 10'd1] <= mem_wdata[15:8];
      if (mem_store_type == ST_SW) begin
        mem[mem_addr[9:0] + 10'd2] <= mem_wdata[23:16];
        mem[mem_addr[9:0] + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    b0 = mem[mem_addr[9:0]];
    b1 = mem[mem_addr[9:0] + 10'd1];
    b2 = mem[mem_addr[9:0] + 10'd2];
    b3 = mem[mem_addr[9:0] + 10'd3];
    mem_wb_data = 32'd0;
    if (mem_read) begin
      case (mem_load_type)
        LD_LB:   mem_wb_data = {{24{b0[7]}}, b0};
        LD_LH:   mem_wb_data = {{16{b1[7]}}, b1, b0};
        LD_LW:   mem_wb_data = {b3, b2, b1, b0};
        LD_LBU:  mem_wb_data = {24'd0, b0};
        LD_LHU:  mem_wb_data = {16'd0, b1, b0};
        default: mem_wb_data = 32'd0;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  int n_applied = 0;
  int n_miscomp = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscomp++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        port;   // 0 = C, 1 = D
    logic        we;
    logic [1:0]  st;
    logic [2:0]  lt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(string name, logic port, logic we, logic [1:0] st,
                              logic [2:0] lt, logic [31:0] addr, logic [31:0] wdata,
                              logic exp_err, logic [31:0] exp_rdata);
    vec_t v;
    v.name = name; v.port = port; v.we = we; v.st = st; v.lt = lt;
    v.addr = addr; v.wdata = wdata; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    c_valid = 1'b0; c_we = 1'b0; c_store_type = 2'b00; c_load_type = 3'b000;
    c_addr = 32'd0; c_wdata = 32'd0;
    d_valid = 1'b0; d_we = 1'b0; d_store_type = 2'b00; d_load_type = 3'b000;
    d_addr = 32'd0; d_wdata = 32'd0;
  endtask

  task automatic drive_c(logic we, logic [1:0] st, logic [2:0] lt, logic [31:0] a, logic [31:0] w);
    c_valid = 1'b1; c_we = we; c_store_type = st; c_load_type = lt; c_addr = a; c_wdata = w;
  endtask

  task automatic drive_d(logic we, logic [1:0] st, logic [2:0] lt, logic [31:0] a, logic [31:0] w);
    d_valid = 1'b1; d_we = we; d_store_type = st; d_load_type = lt; d_addr = a; d_wdata = w;
  endtask

  // One isolated transaction: accepted in its first cycle, response next cycle.
  task automatic issue(input vec_t v);
    logic [32:0] exp;
    if (v.port) drive_d(v.we, v.st, v.lt, v.addr, v.wdata);
    else        drive_c(v.we, v.st, v.lt, v.addr, v.wdata);
    exp_q.push_back({v.exp_err, v.exp_rdata});
    @(negedge clk);
    check({v.name, " ready"}, 32'(v.port ? d_ready : c_ready), 32'd1);
    check({v.name, " mem_read"}, 32'(mem_read), 32'(!v.exp_err && !v.we));
    check({v.name, " mem_write"}, 32'(mem_write), 32'(!v.exp_err && v.we));
    @(posedge clk);
    #1;
    c_valid = 1'b0;
    d_valid = 1'b0;
    check({v.name, " rsp_valid"}, 32'(v.port ? d_rsp_valid : c_rsp_valid), 32'd1);
    if (exp_q.size() == 0) begin
      n_applied++; n_miscomp++;
      $display("FAIL %s: scoreboard queue empty", v.name);
    end else begin
      exp = exp_q.pop_front();
      check({v.name, " rsp_err"}, 32'(v.port ? d_rsp_err : c_rsp_err), 32'(exp[32]));
      check({v.name, " rsp_rdata"}, v.port ? d_rsp_rdata : c_rsp_rdata, exp[31:0]);
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[$];
  logic exp_c [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  int   exp_cnt [6] = '{1, 2, 3, 4, 0, 1};

  initial begin
    vecs.push_back(mk("c_sw_4",     0, 1, ST_SW, LD_LB,  32'h004, 32'hAABBCCDD, 0, 32'h0));
    vecs.push_back(mk("c_lw_4",     0, 0, ST_SB, LD_LW,  32'h004, 32'h0,        0, 32'hAABBCCDD));
    vecs.push_back(mk("c_sb_8",     0, 1, ST_SB, LD_LB,  32'h008, 32'h0000009A, 0, 32'h0));
    vecs.push_back(mk("c_lb_8",     0, 0, ST_SB, LD_LB,  32'h008, 32'h0,        0, 32'hFFFFFF9A));
    vecs.push_back(mk("c_lbu_8",    0, 0, ST_SB, LD_LBU, 32'h008, 32'h0,        0, 32'h0000009A));
    vecs.push_back(mk("d_lh_4",     1, 0, ST_SB, LD_LH,  32'h004, 32'h0,        0, 32'hFFFFCCDD));
    vecs.push_back(mk("d_lhu_6",    1, 0, ST_SB, LD_LHU, 32'h006, 32'h0,        0, 32'h0000AABB));
    vecs.push_back(mk("d_sh_13",    1, 1, ST_SH, LD_LB,  32'h013, 32'h0000FFFF, 1, 32'h0));
    vecs.push_back(mk("d_lw_3fe",   1, 0, ST_SB, LD_LW,  32'h3FE, 32'h0,        1, 32'h0));
    vecs.push_back(mk("d_st11",     1, 1, 2'b11, LD_LB,  32'h010, 32'hDEADBEEF, 1, 32'h0));
    vecs.push_back(mk("c_lt101",    0, 0, ST_SB, 3'b101, 32'h000, 32'h0,        1, 32'h0));
    vecs.push_back(mk("c_lw_400",   0, 0, ST_SB, LD_LW,  32'h400, 32'h0,        1, 32'h0));
    vecs.push_back(mk("c_sb_400",   0, 1, ST_SB, LD_LB,  32'h400, 32'h000000FF, 1, 32'h0));
    vecs.push_back(mk("d_sw_3fc",   1, 1, ST_SW, LD_LB,  32'h3FC, 32'h01020304, 0, 32'h0));
    vecs.push_back(mk("d_lw_3fc",   1, 0, ST_SB, LD_LW,  32'h3FC, 32'h0,        0, 32'h01020304));
    vecs.push_back(mk("d_lh_3fe",   1, 0, ST_SB, LD_LH,  32'h3FE, 32'h0,        0, 32'h00000102));
    vecs.push_back(mk("d_lb_3ff",   1, 0, ST_SB, LD_LB,  32'h3FF, 32'h0,        0, 32'h00000001));
    vecs.push_back(mk("d_lw_10",    1, 0, ST_SB, LD_LW,  32'h010, 32'h0,        0, 32'h0));
    vecs.push_back(mk("c_sw_10_clr",0, 1, ST_SW, LD_LB,  32'h010, 32'h0,        0, 32'h0));

    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset c_ready", 32'(c_ready), 32'd0);
    check("reset c_rsp_valid", 32'(c_rsp_valid), 32'd0);
    check("reset d_rsp_err", 32'(d_rsp_err), 32'd0);
    check("reset c_rsp_rdata", c_rsp_rdata, 32'd0);
    check("reset starve_cnt", 32'(dut.starve_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) issue(vecs[i]);

    // Response fields hold across a cycle with no acceptance.
    issue(mk("d_sh_13_again", 1, 1, ST_SH, LD_LB, 32'h013, 32'h0000FFFF, 1, 32'h0));
    @(posedge clk);
    #1;
    check("hold d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    check("hold d_rsp_err", 32'(d_rsp_err), 32'd1);

    // Starvation: both ports valid; C wins four cycles, D is forced through.
    drive_c(1'b0, ST_SB, LD_LW, 32'h004, 32'h0);
    drive_d(1'b0, ST_SB, LD_LW, 32'h008, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("starve c_ready cyc%0d", i), 32'(c_ready), 32'(exp_c[i]));
      check($sformatf("starve d_ready cyc%0d", i), 32'(d_ready), 32'(!exp_c[i]));
      @(posedge clk);
      #1;
      check($sformatf("starve cnt cyc%0d", i), 32'(dut.starve_cnt), 32'(exp_cnt[i]));
      check($sformatf("starve d_rsp_valid cyc%0d", i), 32'(d_rsp_valid), 32'(!exp_c[i]));
      if (exp_c[i]) check($sformatf("starve c_rdata cyc%0d", i), c_rsp_rdata, 32'hAABBCCDD);
      else          check($sformatf("starve d_rdata cyc%0d", i), d_rsp_rdata, 32'h0000009A);
    end
    idle_inputs();
    @(posedge clk);
    #1;

    // Reset coinciding with a would-be store acceptance.
    rst = 1'b1;
    drive_c(1'b1, ST_SW, LD_LB, 32'h020, 32'h12345678);
    @(negedge clk);
    check("rst c_ready", 32'(c_ready), 32'd0);
    check("rst mem_write", 32'(mem_write), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    c_valid = 1'b0;
    check("rst c_rsp_valid", 32'(c_rsp_valid), 32'd0);
    issue(mk("c_lw_20_after_rst", 0, 0, ST_SB, LD_LW, 32'h020, 32'h0, 0, 32'h0));

    // Simultaneous C SB and D SH into one word; C first, D the cycle after.
    drive_d(1'b1, ST_SH, LD_LB, 32'h012, 32'h0000A5A6);
    drive_c(1'b1, ST_SB, LD_LB, 32'h010, 32'h00000011);
    @(negedge clk);
    check("sim c_ready", 32'(c_ready), 32'd1);
    check("sim d_ready first", 32'(d_ready), 32'd0);
    @(posedge clk);
    #1;
    c_valid = 1'b0;
    check("sim c_rsp_valid", 32'(c_rsp_valid), 32'd1);
    check("sim c_rsp_err", 32'(c_rsp_err), 32'd0);
    @(negedge clk);
    check("sim d_ready second", 32'(d_ready), 32'd1);
    check("sim d mem_write", 32'(mem_write), 32'd1);
    check("sim d mem_addr", mem_addr, 32'h012);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    check("sim d_rsp_valid", 32'(d_rsp_valid), 32'd1);
    check("sim d_rsp_err", 32'(d_rsp_err), 32'd0);
    check("sim c_rsp_valid drop", 32'(c_rsp_valid), 32'd0);
    issue(mk("c_lw_10_merged", 0, 0, ST_SB, LD_LW, 32'h010, 32'h0, 0, 32'hA5A60011));

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscomp);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_memory_unit between two requesters: port C (pipeline MEM stage) and port D (DMA / boot loader).
- Per-cycle grant: fixed priority to C, with a starvation override for D.
- Screens each request for illegal encodings, misalignment and out-of-range addresses before it touches memory.
- Drives the memory's control, address and write-data inputs, and returns a registered per-port response one cycle after acceptance.

Parameters:
- MEM_BYTES, 1024: byte size of the data memory. Any address >= MEM_BYTES is an error.
- STARVE_LIMIT, 4: number of consecutive cycles D may wait while C holds the grant before D is forced through. Must be >= 1.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
c_valid  in  1  port C request valid
c_ready  out  1  port C request accepted this cycle
c_we  in  1  1 = store, 0 = load
c_store_type  in  2  00 SB, 01 SH, 10 SW
c_load_type  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU
c_addr  in  32  byte address
c_wdata  in  32  store data (right-aligned)
c_rsp_valid  out  1  response pulse
c_rsp_err  out  1  request rejected
c_rsp_rdata  out  32  load result (0 for stores and errors)
d_valid, d_ready, d_we, d_store_type, d_load_type, d_addr, d_wdata, d_rsp_valid, d_rsp_err, d_rsp_rdata: identical set for port D
mem_read  out  1  to memory unit
mem_write  out  1  to memory unit
mem_store_type  out  2  to memory unit
mem_load_type  out  3  to memory unit
mem_addr  out  32  drives alu_result
mem_wdata  out  32  drives rs2
mem_memtoreg  out  1  1 whenever mem_read
mem_wb_data  in  32  combinational load result from memory unit

Behaviour:
- Grant (combinational, same cycle):
  - rst=1: no grant.
  - Otherwise, if d_valid and starve_cnt == STARVE_LIMIT: grant D.
  - Otherwise, if c_valid: grant C.
  - Otherwise, if d_valid: grant D.
  - x_ready = grant_x. Acceptance = x_valid & x_ready.
  - A requester holds all request fields stable while valid & !ready.
- Memory drive (acceptance cycle only):
  - Granted request legal: mem_read = !we, mem_write = we, mem_memtoreg = mem_read. Type, address and data fields pass through from the granted port.
  - No grant or illegal request: mem_read = mem_write = 0, and addr/wdata/types driven 0.
  - Store commits at the clk edge that ends the acceptance cycle.
- Legality check. A request is illegal if any of:
  - store_type == 11, or load_type in 101..111.
  - Misaligned: SH or LH/LHU with addr[0] = 1; SW or LW with addr[1:0] != 0.
  - Out of range: addr > MEM_BYTES - size.
  - Illegal requests are still accepted (ready = 1) and produce rsp_err = 1 and rdata = 0. Memory is untouched.
- Response (registered, latency 1): at the edge ending the acceptance cycle, x_rsp_valid <= 1 for the granted port only, with x_rsp_err and x_rsp_rdata as follows:
  - legal load: rdata = mem_wb_data sampled in the acceptance cycle;
  - store or error: rdata = 0.
  - Cycles without acceptance: rsp_valid = 0, and rsp_err/rdata hold their previous values.
- Starvation counter starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments, saturating at STARVE_LIMIT, when d_valid & !grant_d.
  - Cleared when D is granted or d_valid = 0.
- Back-to-back: a new acceptance is allowed every cycle on either port. A response and a new acceptance can coincide.
- Reset:
  - All rsp_valid, rsp_err = 0; rsp_rdata = 0; starve_cnt = 0.
  - Reset asserted in a would-be acceptance cycle: no grant, no memory write, and no response the following cycle.

Decomposition:
- Package dmem_pkg holds the SB/SH/SW and LB/LH/LW/LBU/LHU encodings and the access-size function (type to bytes).
- One sub-module, dmem_req_check: combinational legality check producing an err flag. It takes we, store_type, load_type and addr, with MEM_BYTES as a parameter, and is instantiated once on the muxed request.

Test Plan:
- Scenario 1: C SW 0xAABBCCDD @0x4; next cycle C LW @0x4.
  - Response 1 cycle after each acceptance, err = 0.
  - LW rdata = 0xAABBCCDD.
- Scenario 2: C SB 0x9A @0x8, then LB and LBU @0x8.
  - Responses give rdata 0xFFFFFF9A and 0x0000009A.
- Scenario 3: C and D both valid continuously with STARVE_LIMIT = 4.
  - C granted 4 cycles, then D in cycle 5, then C again.
  - Counter returns to 0 after the D grant.
- Scenario 4: D SH @0x13; D LW @0x3FE; D store_type = 11.
  - Each accepted in 1 cycle with rsp_err = 1 and rdata = 0.
  - mem_write and mem_read never asserted; a follow-up LW @0x10 shows the word unchanged.
- Scenario 5: rst asserted in the same cycle as C SW 0x12345678 @0x20.
  - c_ready = 0, no response.
  - After reset, LW @0x20 returns the prior value (0 after init).
- Scenario 6: D SH 0xA5A6 @0x12 and C SB 0x11 @0x10 presented simultaneously after clearing 0x10.
  - C first, D next cycle.
  - Then LW @0x10 returns 0xA5A60011.
